// File: rtl/temporal_ngram_encoder_pkg.sv
// Shared types and helpers for the temporal N-gram encoder.
// Holds the FSM state encoding and the width helper for the fill counter.
package temporal_ngram_encoder_pkg;

    typedef enum logic {
        ST_ACCEPT        = 1'b0,
        ST_OUTPUT_STABLE = 1'b1
    } state_e;

    // Smallest r with 2**r >= value; used to size the warm-up fill counter.
    function automatic int ceil_log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/temporal_ngram_encoder_hv_permute.sv
// Combinational hypervector permutation: rotate right by SHIFT positions.
// Index 0 is the MSB-side element, so out[k] takes in[k-SHIFT] modulo the width.
module hv_permute #(
    parameter int HV_DIMENSION = 2000,
    parameter int SHIFT        = 1
) (
    input  logic [0:HV_DIMENSION-1] hv_i,
    output logic [0:HV_DIMENSION-1] hv_o
);

    localparam int SHIFT_MOD = SHIFT % HV_DIMENSION;

    genvar gi;
    generate
        for (gi = 0; gi < HV_DIMENSION; gi++) begin : g_bit
            assign hv_o[gi] = hv_i[(gi + HV_DIMENSION - SHIFT_MOD) % HV_DIMENSION];
        end
    endgenerate

endmodule

// File: rtl/temporal_ngram_encoder.sv
// Temporal N-gram encoder: binds each accepted spatial hypervector with the
// permuted previous NGRAM_SIZE-1 inputs and hands the result to the AM.
module temporal_ngram_encoder
    import temporal_ngram_encoder_pkg::*;
#(
    parameter int  HV_DIMENSION = 2000,
    parameter int  NGRAM_SIZE   = 3,
    localparam int FILL_WIDTH   = ceil_log2(NGRAM_SIZE + 1)
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
    input  logic                    ClearHistory_SI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [0:HV_DIMENSION-1] HypervectorOut_DO,
    output logic [FILL_WIDTH-1:0]   FillLevel_SO
);

    localparam logic [FILL_WIDTH-1:0] FILL_MAX = FILL_WIDTH'(NGRAM_SIZE);

    state_e                  state_q, state_d;
    logic [FILL_WIDTH-1:0]   fill_q, fill_d, fill_base;
    logic [0:HV_DIMENSION-1] out_q, out_d;
    logic [0:HV_DIMENSION-1] ngram_hist, ngram;
    logic                    accept, produce;

    assign accept = (state_q == ST_ACCEPT) && ValidIn_SI;

    genvar gi;
    generate
        if (NGRAM_SIZE > 1) begin : g_hist
            logic [0:HV_DIMENSION-1] hist_q [NGRAM_SIZE-1];
            logic [0:HV_DIMENSION-1] hist_d [NGRAM_SIZE-1];
            logic [0:HV_DIMENSION-1] hist_rot [NGRAM_SIZE-1];

            // Entry i is i+1 steps old and therefore gets rho^(i+1).
            for (gi = 0; gi < NGRAM_SIZE - 1; gi++) begin : g_perm
                hv_permute #(
                    .HV_DIMENSION(HV_DIMENSION),
                    .SHIFT       (gi + 1)
                ) u_perm (
                    .hv_i(hist_q[gi]),
                    .hv_o(hist_rot[gi])
                );
            end

            always_comb begin
                ngram_hist = '0;
                for (int i = 0; i < NGRAM_SIZE - 1; i++) begin
                    ngram_hist = ngram_hist ^ hist_rot[i];
                end
            end

            // A clear coincident with an accept empties the window before the shift.
            always_comb begin
                for (int i = 0; i < NGRAM_SIZE - 1; i++) begin
                    hist_d[i] = ClearHistory_SI ? '0 : hist_q[i];
                end
                if (accept) begin
                    hist_d[0] = HypervectorIn_DI;
                    for (int i = 1; i < NGRAM_SIZE - 1; i++) begin
                        hist_d[i] = ClearHistory_SI ? '0 : hist_q[i-1];
                    end
                end
            end

            always_ff @(posedge Clk_CI or posedge Reset_RI) begin
                if (Reset_RI) begin
                    for (int i = 0; i < NGRAM_SIZE - 1; i++) begin
                        hist_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < NGRAM_SIZE - 1; i++) begin
                        hist_q[i] <= hist_d[i];
                    end
                end
            end
        end else begin : g_nohist
            assign ngram_hist = '0;
        end
    endgenerate

    assign ngram = HypervectorIn_DI ^ ngram_hist;

    always_comb begin
        fill_base = ClearHistory_SI ? '0 : fill_q;
        fill_d    = fill_base;
        if (accept && (fill_base != FILL_MAX)) begin
            fill_d = fill_base + 1'b1;
        end
        produce = accept && (fill_d == FILL_MAX);
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        case (state_q)
            ST_ACCEPT: begin
                if (produce) begin
                    state_d = ST_OUTPUT_STABLE;
                    out_d   = ngram;
                end
            end
            ST_OUTPUT_STABLE: begin
                if (ReadyIn_SI) begin
                    state_d = ST_ACCEPT;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            state_q <= ST_ACCEPT;
            fill_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            out_q   <= out_d;
        end
    end

    assign ReadyOut_SO       = (state_q == ST_ACCEPT);
    assign ValidOut_SO       = (state_q == ST_OUTPUT_STABLE);
    assign HypervectorOut_DO = out_q;
    assign FillLevel_SO      = fill_q;

endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// Self-checking bench for temporal_ngram_encoder (D=8 with N=3 and N=1).
// A window-of-inputs reference model predicts outputs; one task per scenario.
module tb_temporal_ngram_encoder;

    localparam int D = 8;
    localparam int N = 3;
    typedef logic [0:D-1] hv_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       vin3 = 1'b0, clr3 = 1'b0, rdy3 = 1'b0;
    hv_t        hv3 = '0;
    logic       ready3, valid3;
    hv_t        out3;
    logic [1:0] fill3;

    logic       vin1 = 1'b0, clr1 = 1'b0, rdy1 = 1'b0;
    hv_t        hv1 = '0;
    logic       ready1, valid1;
    hv_t        out1;
    logic [0:0] fill1;

    temporal_ngram_encoder #(.HV_DIMENSION(D), .NGRAM_SIZE(N)) dut3 (
        .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(vin3), .ReadyOut_SO(ready3),
        .HypervectorIn_DI(hv3), .ClearHistory_SI(clr3), .ValidOut_SO(valid3),
        .ReadyIn_SI(rdy3), .HypervectorOut_DO(out3), .FillLevel_SO(fill3)
    );

    temporal_ngram_encoder #(.HV_DIMENSION(D), .NGRAM_SIZE(1)) dut1 (
        .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(vin1), .ReadyOut_SO(ready1),
        .HypervectorIn_DI(hv1), .ClearHistory_SI(clr1), .ValidOut_SO(valid1),
        .ReadyIn_SI(rdy1), .HypervectorOut_DO(out1), .FillLevel_SO(fill1)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the window is the list of accepted inputs since the last clear.
    hv_t hq[$];
    int  m_fill = 0;
    hv_t m_out = '0;

    function automatic hv_t rot(hv_t x, int j);
        hv_t y;
        for (int k = 0; k < D; k++) y[k] = x[((k - j) % D + D) % D];
        return y;
    endfunction

    function automatic hv_t onehot(int k);
        hv_t v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic model_clear();
        hq.delete();
        m_fill = 0;
    endtask

    task automatic model_accept(input hv_t x, input bit clr, output bit produced);
        hv_t acc;
        if (clr) model_clear();
        m_fill = (m_fill < N) ? m_fill + 1 : N;
        produced = (m_fill == N);
        if (produced) begin
            acc = x;
            for (int j = 1; j < N; j++) acc = acc ^ rot((j <= hq.size()) ? hq[j-1] : hv_t'(0), j);
            m_out = acc;
        end
        hq.push_front(x);
        while (hq.size() > N - 1) void'(hq.pop_back());
    endtask

    // Called at a falling edge; leaves the bench at the falling edge after the accepting edge.
    task automatic drive_accept(input hv_t x, input bit clr, output bit produced);
        int waited = 0;
        while (ready3 !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (ready3 !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL ready_wait: ReadyOut_SO=%b after %0d cycles, required 1", ready3, waited);
        end
        vin3 = 1'b1; hv3 = x; clr3 = clr;
        @(posedge clk);
        model_accept(x, clr, produced);
        @(negedge clk);
        vin3 = 1'b0; clr3 = 1'b0;
    endtask

    task automatic release_out();
        rdy3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy3 = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        vectors++; if (ready3 !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", ready3); end
        vectors++; if (valid3 !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid3); end
        vectors++; if (out3 !== hv_t'(0)) begin miscompares++; $display("FAIL reset_out: got %b want 0", out3); end
        vectors++; if (fill3 !== 2'd0) begin miscompares++; $display("FAIL reset_fill: got %0d want 0", fill3); end
        vectors++; if (ready1 !== 1'b1 || valid1 !== 1'b0) begin miscompares++; $display("FAIL reset_n1: ready=%b valid=%b want 1/0", ready1, valid1); end
        @(negedge clk);
        rst = 1'b0;
        $display("reset: released");
    endtask

    task automatic test_warmup();
        bit p;
        hv_t xs [3];
        xs[0] = onehot(0); xs[1] = onehot(0); xs[2] = '0;
        for (int i = 0; i < 3; i++) begin
            drive_accept(xs[i], 1'b0, p);
            vectors++; if (valid3 !== (i == 2)) begin miscompares++; $display("FAIL warmup_valid[%0d]: got %b want %b", i, valid3, i == 2); end
            vectors++; if (int'(fill3) != i + 1) begin miscompares++; $display("FAIL warmup_fill[%0d]: got %0d want %0d", i, fill3, i + 1); end
            $display("warmup: accept %b fill=%0d valid=%b", xs[i], fill3, valid3);
        end
        vectors++; if (out3 !== (onehot(1) | onehot(2))) begin miscompares++; $display("FAIL warmup_out: got %b want %b", out3, onehot(1) | onehot(2)); end
        release_out();
        vectors++; if (ready3 !== 1'b1 || valid3 !== 1'b0) begin miscompares++; $display("FAIL warmup_release: ready=%b valid=%b want 1/0", ready3, valid3); end
    endtask

    task automatic test_sliding_wrap();
        bit p;
        drive_accept(onehot(7), 1'b0, p);
        vectors++; if (out3 !== (onehot(7) | onehot(2)) || valid3 !== 1'b1) begin miscompares++; $display("FAIL slide_out: got %b valid=%b want %b valid=1", out3, valid3, onehot(7) | onehot(2)); end
        vectors++; if (fill3 !== 2'd3) begin miscompares++; $display("FAIL slide_fill: got %0d want 3", fill3); end
        $display("slide: out=%b", out3);
        release_out();
        drive_accept(onehot(7), 1'b0, p); release_out();
        drive_accept(hv_t'(0), 1'b0, p);  release_out();
        drive_accept(hv_t'(0), 1'b0, p);
        vectors++; if (out3 !== onehot(1)) begin miscompares++; $display("FAIL wrap_out: got %b want %b", out3, onehot(1)); end
        $display("wrap: out=%b", out3);
        release_out();
    endtask

    task automatic test_backpressure();
        bit  p;
        hv_t held;
        drive_accept(hv_t'($urandom_range(0, 255)), 1'b0, p);
        held = out3;
        vectors++; if (held !== m_out) begin miscompares++; $display("FAIL bp_out: got %b want %b", held, m_out); end
        for (int c = 0; c < 5; c++) begin
            vin3 = 1'b1; hv3 = hv_t'($urandom_range(0, 255));
            @(posedge clk); @(negedge clk);
            vectors++; if (out3 !== m_out || valid3 !== 1'b1 || ready3 !== 1'b0) begin miscompares++; $display("FAIL bp_hold[%0d]: out=%b valid=%b ready=%b want %b/1/0", c, out3, valid3, ready3, m_out); end
            $display("backpressure: cycle %0d out=%b", c, out3);
        end
        vin3 = 1'b0;
        release_out();
        vectors++; if (ready3 !== 1'b1 || fill3 !== 2'd3) begin miscompares++; $display("FAIL bp_release: ready=%b fill=%0d want 1/3", ready3, fill3); end
        drive_accept(hv_t'($urandom_range(0, 255)), 1'b0, p);
        vectors++; if (out3 !== m_out) begin miscompares++; $display("FAIL bp_not_consumed: got %b want %b", out3, m_out); end
        release_out();
    endtask

    task automatic test_clear();
        bit  p;
        hv_t y1, y2, y3, prev;
        y1 = hv_t'($urandom_range(0, 255)); y2 = hv_t'($urandom_range(0, 255)); y3 = hv_t'($urandom_range(0, 255));
        vectors++; if (fill3 !== 2'd3) begin miscompares++; $display("FAIL clr_pre_fill: got %0d want 3", fill3); end
        prev = out3;
        drive_accept(y1, 1'b1, p);
        vectors++; if (valid3 !== 1'b0 || fill3 !== 2'd1 || out3 !== prev) begin miscompares++; $display("FAIL clr_accept: valid=%b fill=%0d out=%b want 0/1/%b", valid3, fill3, out3, prev); end
        drive_accept(y2, 1'b0, p);
        drive_accept(y3, 1'b0, p);
        vectors++; if (out3 !== (y3 ^ rot(y2, 1) ^ rot(y1, 2)) || valid3 !== 1'b1) begin miscompares++; $display("FAIL clr_out: got %b valid=%b want %b", out3, valid3, y3 ^ rot(y2, 1) ^ rot(y1, 2)); end
        $display("clear: y=%b,%b,%b out=%b", y1, y2, y3, out3);
        clr3 = 1'b1;
        @(posedge clk); model_clear(); @(negedge clk);
        clr3 = 1'b0;
        vectors++; if (valid3 !== 1'b1 || out3 !== m_out) begin miscompares++; $display("FAIL clr_stable: valid=%b out=%b want 1/%b", valid3, out3, m_out); end
        release_out();
        vectors++; if (fill3 !== 2'd0) begin miscompares++; $display("FAIL clr_stable_fill: got %0d want 0", fill3); end
    endtask

    task automatic test_async_reset();
        bit p;
        int tries = 0;
        p = 1'b0;
        while (!p && tries < N) begin
            drive_accept(hv_t'($urandom_range(1, 255)), 1'b0, p);
            tries++;
        end
        vectors++; if (valid3 !== 1'b1) begin miscompares++; $display("FAIL arst_pre_valid: got %b want 1", valid3); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (valid3 !== 1'b0 || out3 !== hv_t'(0)) begin miscompares++; $display("FAIL arst_immediate: valid=%b out=%b want 0/0", valid3, out3); end
        vectors++; if (ready3 !== 1'b1 || fill3 !== 2'd0) begin miscompares++; $display("FAIL arst_ready_fill: ready=%b fill=%0d want 1/0", ready3, fill3); end
        @(negedge clk);
        rst = 1'b0;
        model_clear(); m_out = '0;
        for (int i = 0; i < 3; i++) begin
            drive_accept(hv_t'($urandom_range(0, 255)), 1'b0, p);
            vectors++; if (valid3 !== (i == 2) || out3 !== m_out) begin miscompares++; $display("FAIL arst_refill[%0d]: valid=%b out=%b want %b/%b", i, valid3, out3, i == 2, m_out); end
            $display("async_reset: refill %0d valid=%b", i, valid3);
        end
        release_out();
    endtask

    task automatic test_ngram1();
        hv_t x;
        for (int i = 0; i < 5; i++) begin
            x = (i == 0) ? onehot(3) : hv_t'($urandom_range(0, 255));
            vin1 = 1'b1; hv1 = x; clr1 = (i == 2);
            @(posedge clk); @(negedge clk);
            vin1 = 1'b0; clr1 = 1'b0;
            vectors++; if (valid1 !== 1'b1 || out1 !== x || fill1 !== 1'b1) begin miscompares++; $display("FAIL n1_out[%0d]: valid=%b out=%b fill=%0d want 1/%b/1", i, valid1, out1, fill1, x); end
            $display("ngram1: in=%b out=%b", x, out1);
            rdy1 = 1'b1;
            @(posedge clk); @(negedge clk);
            rdy1 = 1'b0;
            vectors++; if (ready1 !== 1'b1 || valid1 !== 1'b0) begin miscompares++; $display("FAIL n1_release[%0d]: ready=%b valid=%b want 1/0", i, ready1, valid1); end
        end
    endtask

    task automatic test_random();
        bit  p, c;
        hv_t x;
        for (int it = 0; it < 60; it++) begin
            x = hv_t'($urandom_range(0, 255));
            drive_accept(x, ($urandom_range(0, 7) == 0), p);
            vectors++; if (valid3 !== p || out3 !== m_out || int'(fill3) != m_fill) begin miscompares++; $display("FAIL rand_accept[%0d]: valid=%b out=%b fill=%0d want %b/%b/%0d", it, valid3, out3, fill3, p, m_out, m_fill); end
            $display("random[%0d]: in=%b valid=%b out=%b fill=%0d", it, x, valid3, out3, fill3);
            if (p) begin
                for (int b = $urandom_range(0, 3); b > 0; b--) begin
                    c = ($urandom_range(0, 5) == 0);
                    vin3 = 1'(($urandom_range(0, 1))); hv3 = hv_t'($urandom_range(0, 255)); clr3 = c;
                    @(posedge clk);
                    if (c) model_clear();
                    @(negedge clk);
                    vin3 = 1'b0; clr3 = 1'b0;
                    vectors++; if (valid3 !== 1'b1 || ready3 !== 1'b0 || out3 !== m_out) begin miscompares++; $display("FAIL rand_hold[%0d]: valid=%b ready=%b out=%b want 1/0/%b", it, valid3, ready3, out3, m_out); end
                end
                release_out();
                vectors++; if (ready3 !== 1'b1 || int'(fill3) != m_fill) begin miscompares++; $display("FAIL rand_release[%0d]: ready=%b fill=%0d want 1/%0d", it, ready3, fill3, m_fill); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_sliding_wrap();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_ngram1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/temporal_ngram_encoder.md
Name: temporal_ngram_encoder

Overview:
Upstream transmitter feeding the associative-memory query port. It accepts one spatially-encoded hypervector per handshake. It binds it with the permuted previous NGRAM_SIZE-1 inputs to form a temporal N-gram hypervector. It presents the result on a ValidOut/ReadyIn handshake to the AM. One instance per modality; the three outputs drive the AM's mod1/mod2/mod3 inputs.

Parameters:
HV_DIMENSION, 2000, hypervector width in bits; bit 0 is the MSB-side index, vectors declared [0:HV_DIMENSION-1].
NGRAM_SIZE, 3, N-gram length; legal range 1..8.
FILL_WIDTH, ceilLog2(NGRAM_SIZE+1), width of the warm-up fill counter (derived, not overridden).

Ports:
Clk_CI  in  1  clock, rising edge.
Reset_RI  in  1  reset.
ValidIn_SI  in  1  upstream spatial HV valid.
ReadyOut_SO  out  1  encoder can accept an input this cycle.
HypervectorIn_DI  in  HV_DIMENSION  spatial hypervector.
ClearHistory_SI  in  1  synchronous window flush (e.g. new trial).
ValidOut_SO  out  1  N-gram output valid.
ReadyIn_SI  in  1  downstream (AM) ready.
HypervectorOut_DO  out  HV_DIMENSION  registered N-gram hypervector.
FillLevel_SO  out  FILL_WIDTH  number of valid history entries plus the current one, saturating at NGRAM_SIZE.

Interface fixed: one clock Clk_CI; reset Reset_RI is asynchronous, active-high.

Behaviour:
- Permutation rho: rotate right by 1. rho(x)[0]=x[D-1]; rho(x)[k]=x[k-1]. rho^j is j rotations.
- History registers H[0..N-2]; H[0] is the newest accepted input.
- N-gram = In XOR rho(H[0]) XOR rho^2(H[1]) ... XOR rho^(N-1)(H[N-2]).
- NGRAM_SIZE=1: output = In, no history, no warm-up.
- FSM states:
  - ACCEPT: ReadyOut_SO=1, ValidOut_SO=0.
  - OUTPUT_STABLE: ReadyOut_SO=0, ValidOut_SO=1.
- ACCEPT with ValidIn_SI=1 (accept):
  - Shift history: H[0]<=In, H[i]<=H[i-1].
  - FillCntr increments, saturating at NGRAM_SIZE.
  - If FillCntr after increment equals NGRAM_SIZE: the N-gram (computed from pre-shift history and In) is registered into HypervectorOut_DO, and the FSM goes to OUTPUT_STABLE.
  - Otherwise (warm-up): stay in ACCEPT; the output register is unchanged.
- Latency: ValidOut_SO rises the cycle after the accepting edge.
- OUTPUT_STABLE: HypervectorOut_DO is held stable while ReadyIn_SI=0. When ReadyIn_SI=1, go to ACCEPT next cycle. The output register keeps its value; ValidOut_SO drops.
- Throughput: max one N-gram per 2 cycles. This matches the AM, which accepts only in IDLE.
- Sliding window: after warm-up, each subsequent accept produces an output. FillCntr stays at NGRAM_SIZE.
- ClearHistory_SI (sampled every cycle, any state):
  - Zeroes H[*] and FillCntr.
  - If coincident with an accept: clear first, then the accepted input enters as H[0] with FillCntr=1, and no output is produced (unless NGRAM_SIZE=1).
  - In OUTPUT_STABLE: the pending output and its handshake are unaffected.
- ValidIn_SI in OUTPUT_STABLE is ignored; the input is not consumed.
- Reset (asynchronous, mid-operation included): state ACCEPT, H[*]=0, FillCntr=0, HypervectorOut_DO=0.
  - Output reset values: ValidOut_SO=0, ReadyOut_SO=1 (decoded from ACCEPT), FillLevel_SO=0.
- ValidOut_SO and ReadyOut_SO are Moore outputs decoded from state only.

Decomposition:
- const.vh: HV_DIMENSION, NGRAM_SIZE, the ceilLog2 macro, and state encodings (ACCEPT=1'b0, OUTPUT_STABLE=1'b1).
- Sub-module hv_permute: parameters HV_DIMENSION and SHIFT; combinational rotate-right by SHIFT. It is instantiated NGRAM_SIZE-1 times via generate.

Test Plan:
All scenarios use D=8, N=3 unless stated; bit k denotes index k.
1. Warm-up and first output:
   - Stimulus: accept x1={bit0}, x2={bit0}, x3=0; ReadyIn_SI=1.
   - Response: no ValidOut after x1 or x2. After x3, ValidOut_SO=1 one cycle later with Out={bit1,bit2}. FillLevel_SO reads 1, 2, 3.
2. Backpressure:
   - Stimulus: hold ReadyIn_SI=0 for 5 cycles after an output.
   - Response: Out and ValidOut_SO stay constant; ReadyOut_SO=0 throughout; ValidIn pulses are not consumed. ReadyIn_SI=1 returns the FSM to ACCEPT the next cycle.
3. Sliding window and wrap:
   - Stimulus: after scenario 1, accept x4={bit7}.
   - Response: Out = x4 ^ rho(x3) ^ rho^2(x2) = {bit7, bit2}. Rotation wraps from bit7 to bit0 correctly: an x2 of {bit7} contributes bit1.
4. ClearHistory:
   - Stimulus A: with FillLevel=3, assert ClearHistory_SI coincident with accept of y1.
   - Response A: no output; FillLevel=1.
   - Stimulus B: accept two more inputs.
   - Response B: output = y3 ^ rho(y2) ^ rho^2(y1).
5. Asynchronous reset in OUTPUT_STABLE:
   - Stimulus: assert Reset_RI mid-cycle.
   - Response: ValidOut_SO=0 and HypervectorOut_DO=0 immediately, without waiting for a clock edge. After release, ReadyOut_SO=1 and three accepts are needed for the next output.
6. NGRAM_SIZE=1:
   - Stimulus: accept x={bit3}.
   - Response: Out={bit3} on the next cycle; FillLevel_SO=1.
